// File: rtl/sad_min_select.sv
// Minimum-SAD tracker over a raster-ordered square search window; reports the winning vector.
// Optional early termination on a SAD threshold is enabled by defining EARLY_TERM_EN.
module sad_min_select #(
    parameter int SAD_W  = 12,
    parameter int SRCH_N = 16,
    parameter int IDX_W  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sad_valid,
    input  logic [SAD_W-1:0] sad_in,
`ifdef EARLY_TERM_EN
    input  logic [SAD_W-1:0] thresh,
`endif
    output logic             busy,
    output logic             done,
    output logic [IDX_W-1:0] cand_x,
    output logic [IDX_W-1:0] cand_y,
    output logic [SAD_W-1:0] best_sad,
    output logic [IDX_W-1:0] best_x,
    output logic [IDX_W-1:0] best_y
`ifdef EARLY_TERM_EN
    ,
    output logic             early
`endif
);

    typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SRCH_N - 1);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   cand_x_q, cand_x_d;
    logic [IDX_W-1:0]   cand_y_q, cand_y_d;
    logic [SAD_W-1:0]   best_sad_q, best_sad_d;
    logic [IDX_W-1:0]   best_x_q, best_x_d;
    logic [IDX_W-1:0]   best_y_q, best_y_d;
    logic               first_q, first_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               last_x, last_y;
`ifdef EARLY_TERM_EN
    logic               early_q, early_d;
`endif

    always_comb begin
        state_d    = state_q;
        cand_x_d   = cand_x_q;
        cand_y_d   = cand_y_q;
        best_sad_d = best_sad_q;
        best_x_d   = best_x_q;
        best_y_d   = best_y_q;
        first_d    = first_q;
        last_x     = (cand_x_q == LAST_IDX);
        last_y     = (cand_y_q == LAST_IDX);
`ifdef EARLY_TERM_EN
        early_d    = early_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = SEARCH;
                    cand_x_d = '0;
                    cand_y_d = '0;
                    first_d  = 1'b1;
`ifdef EARLY_TERM_EN
                    early_d  = 1'b0;
`endif
                end
            end
            SEARCH: begin
                if (sad_valid) begin
                    // Strict compare keeps the earlier raster candidate on ties.
                    if (first_q || (sad_in < best_sad_q)) begin
                        best_sad_d = sad_in;
                        best_x_d   = cand_x_q;
                        best_y_d   = cand_y_q;
                    end
                    first_d = 1'b0;
                    if (last_x) begin
                        cand_x_d = '0;
                        cand_y_d = last_y ? '0 : cand_y_q + 1'b1;
                    end else begin
                        cand_x_d = cand_x_q + 1'b1;
                    end
                    if (last_x && last_y) begin
                        state_d = DONE;
                    end
`ifdef EARLY_TERM_EN
                    if (sad_in < thresh) begin
                        state_d = DONE;
                        early_d = 1'b1;
                    end
`endif
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == SEARCH);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            cand_x_q   <= '0;
            cand_y_q   <= '0;
            best_sad_q <= '0;
            best_x_q   <= '0;
            best_y_q   <= '0;
            first_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef EARLY_TERM_EN
            early_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cand_x_q   <= cand_x_d;
            cand_y_q   <= cand_y_d;
            best_sad_q <= best_sad_d;
            best_x_q   <= best_x_d;
            best_y_q   <= best_y_d;
            first_q    <= first_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef EARLY_TERM_EN
            early_q    <= early_d;
`endif
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign cand_x   = cand_x_q;
    assign cand_y   = cand_y_q;
    assign best_sad = best_sad_q;
    assign best_x   = best_x_q;
    assign best_y   = best_y_q;
`ifdef EARLY_TERM_EN
    assign early    = early_q;
`endif

endmodule

// File: tb/tb_sad_min_select.sv
// Bench for sad_min_select: SRCH_N=4 and SRCH_N=2 instances, queue scoreboard of expected winners.
module tb_sad_min_select;

    typedef struct {
        logic [11:0] sad;
        logic [3:0]  x;
        logic [3:0]  y;
        logic        early;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start4 = 1'b0, valid4 = 1'b0;
    logic [11:0] sad4 = '0, thr = '0;
    logic        busy4, done4, early4;
    logic [3:0]  cx4, cy4, bx4, by4;
    logic [11:0] bs4;
    logic        start2 = 1'b0, valid2 = 1'b0;
    logic [11:0] sad2 = '0, thr2 = '0;
    logic        busy2, done2, early2;
    logic [3:0]  cx2, cy2, bx2, by2;
    logic [11:0] bs2;

    logic [11:0] samp [16];
    exp_t        sb [$];
    exp_t        last_res;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    sad_min_select #(.SAD_W(12), .SRCH_N(4), .IDX_W(4)) u4 (
        .clk(clk), .reset(reset), .start(start4), .sad_valid(valid4), .sad_in(sad4),
`ifdef EARLY_TERM_EN
        .thresh(thr), .early(early4),
`endif
        .busy(busy4), .done(done4), .cand_x(cx4), .cand_y(cy4),
        .best_sad(bs4), .best_x(bx4), .best_y(by4)
    );

    sad_min_select #(.SAD_W(12), .SRCH_N(2), .IDX_W(4)) u2 (
        .clk(clk), .reset(reset), .start(start2), .sad_valid(valid2), .sad_in(sad2),
`ifdef EARLY_TERM_EN
        .thresh(thr2), .early(early2),
`endif
        .busy(busy2), .done(done2), .cand_x(cx2), .cand_y(cy2),
        .best_sad(bs2), .best_x(bx2), .best_y(by2)
    );

`ifndef EARLY_TERM_EN
    assign early4 = 1'b0;
    assign early2 = 1'b0;
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one SRCH_N=4 search from samp[], model-predicting winner, length and early flag.
    task automatic run_search4(input string name, input bit stall, input bit hold_start);
        exp_t e;
        exp_t got;
        int   n_exp, bi, acc, cyc;
        bit   v, trig;
        n_exp = 16; bi = 0; trig = 0;
        for (int k = 0; k < 16; k++) begin
            if (k == 0 || samp[k] < samp[bi]) bi = k;
            if (thr != 0 && samp[k] < thr) begin
                n_exp = k + 1;
                trig = 1;
                break;
            end
        end
        e.sad = samp[bi];
        e.x = 4'(bi % 4);
        e.y = 4'(bi / 4);
`ifdef EARLY_TERM_EN
        e.early = trig;
`else
        e.early = 1'b0;
`endif
        sb.push_back(e);

        start4 = 1'b1;
        tick();
        checks++;
        if (busy4 !== 1'b1) begin
            errors++; $display("FAIL %s busy_after_start got=%0b exp=1", name, busy4);
        end
        start4 = hold_start;
        acc = 0; cyc = 0;
        while (acc < n_exp && cyc < 200) begin
            v = stall ? (cyc % 2 == 0) : 1'b1;
            if (v) begin
                checks++;
                if (cx4 !== 4'(acc % 4) || cy4 !== 4'(acc / 4)) begin
                    errors++;
                    $display("FAIL %s cand got=(%0d,%0d) exp=(%0d,%0d)", name, cx4, cy4, acc % 4, acc / 4);
                end
            end
            valid4 = v;
            sad4 = v ? samp[acc] : 12'd0;
            tick();
            if (v) acc++;
            cyc++;
            if (acc < n_exp && done4 === 1'b1) begin
                errors++; checks++;
                $display("FAIL %s premature_done after %0d samples", name, acc);
            end
        end
        valid4 = 1'b0;
        checks++;
        if (acc < n_exp) begin
            errors++; $display("FAIL %s timeout accepted=%0d exp=%0d", name, acc, n_exp);
        end
        checks++;
        if (done4 !== 1'b1 || busy4 !== 1'b0) begin
            errors++; $display("FAIL %s done_timing done=%0b busy=%0b exp done=1 busy=0", name, done4, busy4);
        end
        if (sb.size() > 0) begin
            got = sb.pop_front();
            checks++;
            if (bs4 !== got.sad || bx4 !== got.x || by4 !== got.y) begin
                errors++;
                $display("FAIL %s best got=%0d@(%0d,%0d) exp=%0d@(%0d,%0d)", name, bs4, bx4, by4, got.sad, got.x, got.y);
            end
            checks++;
            if (early4 !== got.early) begin
                errors++; $display("FAIL %s early got=%0b exp=%0b", name, early4, got.early);
            end
            last_res = got;
        end
        checks++;
        if (cx4 !== 4'(n_exp % 4) || cy4 !== 4'((n_exp / 4) % 4)) begin
            errors++;
            $display("FAIL %s cand_after got=(%0d,%0d) exp=(%0d,%0d)", name, cx4, cy4, n_exp % 4, (n_exp / 4) % 4);
        end
        tick();
        start4 = 1'b0;
        checks++;
        if (done4 !== 1'b0 || busy4 !== 1'b0) begin
            errors++; $display("FAIL %s done_pulse_width done=%0b busy=%0b exp 0,0", name, done4, busy4);
        end
        tick();
        checks++;
        if (busy4 !== 1'b0 || done4 !== 1'b0) begin
            errors++; $display("FAIL %s restarted busy=%0b done=%0b exp 0,0", name, busy4, done4);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick(); tick();
        checks++;
        if ({busy4, done4, cx4, cy4, bs4, bx4, by4, early4} !== '0 || {busy2, done2, bs2} !== '0) begin
            errors++; $display("FAIL reset_init busy=%0b done=%0b best=%0d exp all 0", busy4, done4, bs4);
        end
        reset = 1'b1;
        tick();
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            valid4 = 1'b1;
            sad4 = 12'(50 + i);
            tick();
        end
        valid4 = 1'b0;
        checks++;
        if (busy4 !== 1'b1 || cx4 !== 4'd1 || cy4 !== 4'd1) begin
            errors++; $display("FAIL reset_presearch busy=%0b cand=(%0d,%0d) exp 1,(1,1)", busy4, cx4, cy4);
        end
        reset = 1'b0;
        tick();
        checks++;
        if ({busy4, done4, cx4, cy4, bs4, bx4, by4, early4} !== '0) begin
            errors++; $display("FAIL reset_mid busy=%0b done=%0b cand=(%0d,%0d) best=%0d exp all 0", busy4, done4, cx4, cy4, bs4);
        end
        tick();
        reset = 1'b1;
        tick();
        checks++;
        if (busy4 !== 1'b0 || done4 !== 1'b0 || bs4 !== 12'd0) begin
            errors++; $display("FAIL reset_idle busy=%0b done=%0b best=%0d exp 0,0,0", busy4, done4, bs4);
        end
    endtask

    task automatic test_full_search();
        for (int i = 0; i < 16; i++) samp[i] = 12'd100;
        samp[1 * 4 + 2] = 12'd37;
        run_search4("full_search", 1'b0, 1'b0);
    endtask

    task automatic test_tie_stall();
        for (int i = 0; i < 16; i++) samp[i] = 12'd200;
        samp[1] = 12'd5;
        samp[2 * 4 + 3] = 12'd5;
        run_search4("tie_stall", 1'b1, 1'b0);
    endtask

    task automatic test_protocol();
        for (int i = 0; i < 16; i++) samp[i] = 12'($urandom_range(1, 4095));
        run_search4("protocol", 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            valid4 = 1'b1;
            sad4 = 12'd0;
            tick();
            valid4 = 1'b0;
            tick();
        end
        checks++;
        if (bs4 !== last_res.sad || bx4 !== last_res.x || by4 !== last_res.y || busy4 !== 1'b0) begin
            errors++;
            $display("FAIL idle_valid best=%0d@(%0d,%0d) busy=%0b exp=%0d@(%0d,%0d) busy=0", bs4, bx4, by4, busy4, last_res.sad, last_res.x, last_res.y);
        end
    endtask

    task automatic test_max_value();
        exp_t e;
        exp_t got;
        e.sad = 12'd4095; e.x = 4'd0; e.y = 4'd0; e.early = 1'b0;
        sb.push_back(e);
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            valid2 = 1'b1;
            sad2 = 12'd4095;
            tick();
            if (i < 3 && done2 === 1'b1) begin
                errors++; checks++; $display("FAIL max_value premature_done at sample %0d", i);
            end
        end
        valid2 = 1'b0;
        got = sb.pop_front();
        checks++;
        if (done2 !== 1'b1 || bs2 !== got.sad || bx2 !== got.x || by2 !== got.y) begin
            errors++;
            $display("FAIL max_value done=%0b best=%0d@(%0d,%0d) exp done=1 %0d@(%0d,%0d)", done2, bs2, bx2, by2, got.sad, got.x, got.y);
        end
        tick();
        checks++;
        if (done2 !== 1'b0 || cx2 !== 4'd0 || cy2 !== 4'd0) begin
            errors++; $display("FAIL max_value_after done=%0b cand=(%0d,%0d) exp 0,(0,0)", done2, cx2, cy2);
        end
    endtask

`ifdef EARLY_TERM_EN
    task automatic test_early_term();
        for (int i = 0; i < 16; i++) samp[i] = 12'd100;
        samp[0] = 12'd50;
        samp[1] = 12'd40;
        samp[2] = 12'd8;
        thr = 12'd10;
        run_search4("early_term", 1'b0, 1'b0);
        samp[2] = 12'd0;
        samp[9] = 12'd0;
        thr = 12'd0;
        run_search4("thresh_zero", 1'b0, 1'b0);
    endtask
`endif

    initial begin
        test_reset();
        test_full_search();
        test_tie_stall();
        test_protocol();
        test_max_value();
`ifdef EARLY_TERM_EN
        test_early_term();
`endif
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL scoreboard_leftover entries=%0d exp=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sad_min_select.md
Name: sad_min_select

Overview:
- Downstream consumer of the 4x4 SAD processing element.
- Accepts one 12-bit SAD per candidate displacement, in raster order over a square search window.
- Tracks the minimum SAD and its candidate coordinates, and reports the winning motion vector with a one-cycle done pulse.
- Sits between the PE array and the motion-vector writeback logic.

Parameters:
- SAD_W, 12, width of incoming SAD and of best_sad (matches PE sum width).
- SRCH_N, 16, candidate positions per axis; total candidates = SRCH_N*SRCH_N; legal range 2..2**IDX_W.
- IDX_W, 4, width of the candidate x/y index outputs.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset.
- start  input  1  begin a new search; sampled only in IDLE.
- sad_valid  input  1  sad_in holds the SAD for candidate (cand_x, cand_y).
- sad_in  input  SAD_W  SAD value from the PE.
- thresh  input  SAD_W  early-termination threshold; present only with EARLY_TERM_EN.
- busy  output  1  high while in SEARCH.
- done  output  1  one-cycle pulse; best_* are valid and stable from this cycle.
- cand_x  output  IDX_W  column index of the next expected candidate.
- cand_y  output  IDX_W  row index of the next expected candidate.
- best_sad  output  SAD_W  minimum SAD found.
- best_x  output  IDX_W  column index of the minimum.
- best_y  output  IDX_W  row index of the minimum.
- early  output  1  set when the search ended by threshold; present only with EARLY_TERM_EN.

Behaviour:
- Clock and reset: clk rising edge only. reset is synchronous and active-low, sampled on the clk edge.
- Reset (reset==0 at an edge) has top priority, including mid-search: state=IDLE, and busy, done, cand_x, cand_y, best_sad, best_x, best_y, early are all 0.
- All outputs are registered.
- FSM states: IDLE, SEARCH, DONE.
- IDLE:
  - start==1 -> SEARCH next cycle; cand_x=cand_y=0; first-sample flag set; early=0.
  - sad_valid is ignored.
  - best_* hold their previous results.
- SEARCH:
  - busy=1.
  - Each cycle with sad_valid==1 is one accepted sample for (cand_x, cand_y).
  - Cycles with sad_valid==0 are stalls; nothing changes.
  - start is ignored.
- Update rule on an accepted sample:
  - If first sample, or sad_in < best_sad (unsigned, strict): best_sad<=sad_in, best_x<=cand_x, best_y<=cand_y.
  - Ties keep the earlier raster candidate.
  - The first-sample flag then clears.
- Counter advance: cand_x increments per accepted sample. At cand_x==SRCH_N-1 it wraps to 0 and cand_y increments.
- Last candidate: an accepted sample at (SRCH_N-1, SRCH_N-1) -> DONE next cycle, busy=0. Counters wrap to (0,0).
- DONE: done=1 for exactly one cycle, then IDLE unconditionally. start asserted in DONE is ignored; the upstream must re-assert it in IDLE.
- Latency: done rises the cycle after the last accepted sample; best_* are updated on that same edge.
- Results: best_* stay stable from done until the next accepted sample of a new search.
- Width: the SAD comparison is pure unsigned SAD_W; no saturation is needed.

Optional Feature:
- Macro: EARLY_TERM_EN.
- Defined:
  - thresh and early ports exist.
  - In SEARCH, an accepted sample with sad_in < thresh updates best_* (it is necessarily the new minimum or the first sample) and goes to DONE next cycle. early=1 is held until the next start or reset.
  - Counters are left at the next candidate index.
  - thresh==0 never triggers.
- Undefined: no thresh or early ports; every search covers all SRCH_N*SRCH_N candidates.

Test Plan:
- Reset: reset=0 for 2 cycles mid-search (SRCH_N=4, after 5 samples) -> next cycle busy=0, done=0, all outputs 0, state IDLE; a following start runs a clean 16-sample search.
- Full search (SRCH_N=4): start, then 16 back-to-back samples with value 100 except candidate (2,1)=37 -> done the cycle after the 16th sample, best_sad=37, best_x=2, best_y=1.
- Tie and stall (SRCH_N=4): candidates (1,0) and (3,2) both 5, others 200, sad_valid toggled 1/0 every cycle -> best_sad=5, best_x=1, best_y=0; done exactly one cycle after the 16th accepted sample.
- Protocol: start held high through the whole search and during DONE -> exactly one search and one done pulse; sad_valid pulses in IDLE do not change best_*.
- Max value (SRCH_N=2): all four samples = 4095 -> best_sad=4095, best_x=0, best_y=0.
- EARLY_TERM_EN (SRCH_N=4, thresh=10): samples 50,40,8,... -> done the cycle after the 3rd sample, early=1, best_sad=8, best_x=2, best_y=0; with thresh=0 the search covers all 16 candidates.
